// File: rtl/dac_pkg.sv
// Shared definitions for the serial DAC transmitter: framing modes,
// controller states and a frame-length helper.
package dac_pkg;

  typedef enum logic [1:0] {
    MODE_I2S  = 2'd0,
    MODE_LJ   = 2'd1,
    MODE_TDM  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Number of sclk periods in one frame.
  function automatic int frame_len(input int channels, input int slot_width);
    return channels * slot_width;
  endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// Bit-clock generator: divides clk by 2*SCLK_DIV and flags the cycle in
// which sclk is about to rise or fall. Held cleared while not running.
module dac_sclk_gen #(
  parameter int SCLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  output logic sclk_o,
  output logic fall_o,
  output logic rise_o
);

  localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          sclk_q;
  logic          tick;

  assign tick   = (cnt_q == CW'(SCLK_DIV - 1));
  assign fall_o = run_i & tick & sclk_q;
  assign rise_o = run_i & tick & ~sclk_q;
  assign sclk_o = sclk_q;

  // Half-period counter; sclk toggles when the counter wraps.
  always_ff @(posedge clk) begin
    if (reset || !run_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (tick) begin
      cnt_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/tdm_dac_transmitter.sv
// N-channel serial audio transmitter (I2S, left-justified, TDM/DSP-A).
// Frames enter a one-deep buffer over valid/ready and are serialised
// MSB first, one channel per slot, with zero padding after each sample.
module tdm_dac_transmitter
  import dac_pkg::*;
#(
  parameter int WIDTH      = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int CHANNELS   = 2,
  parameter int SCLK_DIV   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [1:0]                   mode,
  input  logic [CHANNELS*WIDTH-1:0]    frame_data,
  input  logic                         frame_valid,
  output logic                         frame_ready,
  output logic                         sclk,
  output logic                         lrclk,
  output logic                         sd,
  output logic                         underrun
);

  localparam int DW   = CHANNELS * WIDTH;
  localparam int SW_W = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_e            state_q;
  mode_e             mode_q;
  logic [DW-1:0]     buf_q;
  logic              full_q;
  logic              ready_q;
  logic [DW-1:0]     frame_q;
  logic [CH_W-1:0]   slot_q;
  logic [SW_W-1:0]   bit_q;
  logic              sd_q;
  logic              lrclk_q;
  logic              underrun_q;

  logic              sclk_fall;
  logic              sclk_rise;
  logic              last_bit;
  logic              last_slot;
  logic              frame_end;
  logic [CH_W-1:0]   nxt_slot;
  logic [SW_W-1:0]   nxt_bit;
  logic [DW-1:0]     load_frame;
  logic              hs;
  logic              start;
  logic              wrap;
  logic              load;
  logic              stop;
  logic              full_d;
  mode_e             mode_d;

  // Serial bit of slot s, slot bit b: sample MSB first, then zero padding.
  function automatic logic data_bit(input logic [DW-1:0] f, input int s, input int b);
    logic r;
    r = 1'b0;
    if (b < WIDTH) r = f[s*WIDTH + (WIDTH - 1 - b)];
    return r;
  endfunction

  // Word-select level presented together with position (s, b).
  function automatic logic lr_level(input mode_e m, input int s, input int b);
    int   ns;
    logic r;
    ns = s;
    if (b == SLOT_WIDTH - 1) ns = (s == CHANNELS - 1) ? 0 : s + 1;
    case (m)
      MODE_TDM: r = (s == CHANNELS - 1) && (b == SLOT_WIDTH - 1);
      MODE_LJ:  r = (s >= CHANNELS / 2);
      default:  r = (ns >= CHANNELS / 2);  // I2S leads the slot by one bit
    endcase
    return r;
  endfunction

  dac_sclk_gen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_sclk_gen (
    .clk    (clk),
    .reset  (reset),
    .run_i  (state_q == ST_RUN),
    .sclk_o (sclk),
    .fall_o (sclk_fall),
    .rise_o (sclk_rise)
  );

  // Position stepping, frame boundary decisions and buffer bookkeeping.
  always_comb begin
    last_bit   = (bit_q == SW_W'(SLOT_WIDTH - 1));
    last_slot  = (slot_q == CH_W'(CHANNELS - 1));
    frame_end  = last_bit && last_slot;
    nxt_bit    = last_bit ? '0 : bit_q + SW_W'(1);
    nxt_slot   = slot_q;
    if (last_bit) nxt_slot = last_slot ? '0 : slot_q + CH_W'(1);
    load_frame = full_q ? buf_q : '0;
    hs         = frame_valid && ready_q;
    start      = (state_q == ST_IDLE) && enable && full_q;
    wrap       = (state_q == ST_RUN) && sclk_fall && frame_end;
    load       = start || (wrap && enable);
    stop       = wrap && !enable;
    full_d     = (full_q && !load) || hs;
    mode_d     = (mode == 2'd3) ? MODE_I2S : mode_e'(mode);
  end

  // Controller FSM with registered serial outputs and frame buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_I2S;
      buf_q      <= '0;
      full_q     <= 1'b0;
      ready_q    <= 1'b1;
      frame_q    <= '0;
      slot_q     <= '0;
      bit_q      <= '0;
      sd_q       <= 1'b0;
      lrclk_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      ready_q    <= !full_d;
      underrun_q <= 1'b0;
      if (hs) buf_q <= frame_data;

      case (state_q)
        ST_IDLE: begin
          sd_q    <= 1'b0;
          lrclk_q <= 1'b0;
          if (start) begin
            state_q <= ST_RUN;
            mode_q  <= mode_d;
            frame_q <= buf_q;
            slot_q  <= '0;
            bit_q   <= '0;
            // I2S position 0 would carry the previous frame's last bit; none exists.
            sd_q    <= (mode_d == MODE_I2S) ? 1'b0 : data_bit(buf_q, 0, 0);
            lrclk_q <= lr_level(mode_d, 0, 0);
          end
        end
        default: begin
          if (sclk_fall) begin
            if (stop) begin
              state_q <= ST_IDLE;
              slot_q  <= '0;
              bit_q   <= '0;
              sd_q    <= 1'b0;
              lrclk_q <= 1'b0;
            end else begin
              slot_q  <= nxt_slot;
              bit_q   <= nxt_bit;
              if (frame_end) begin
                frame_q    <= load_frame;
                underrun_q <= !full_q;
              end
              if (mode_q == MODE_I2S)
                sd_q <= data_bit(frame_q, int'(slot_q), int'(bit_q));
              else
                sd_q <= data_bit(frame_end ? load_frame : frame_q, int'(nxt_slot), int'(nxt_bit));
              lrclk_q <= lr_level(mode_q, int'(nxt_slot), int'(nxt_bit));
            end
          end
        end
      endcase
    end
  end

  assign frame_ready = ready_q;
  assign lrclk       = lrclk_q;
  assign sd          = sd_q;
  assign underrun    = underrun_q;

  // sclk_rise is not needed by the controller; outputs only move on falls.
  logic unused_rise;
  assign unused_rise = sclk_rise;

endmodule

// File: tb/tb_tdm_dac_transmitter.sv
// Self-checking bench: a receiver model samples sd/lrclk on sclk rising,
// rebuilds channel words and compares them with a scoreboard of frames.
module tb_tdm_dac_transmitter;

  localparam int W   = 24;
  localparam int SW  = 32;
  localparam int DIV = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [47:0] data_a;
  logic [95:0] data_b;
  logic        valid_a, valid_b;
  logic        ready_a, ready_b;
  logic        sclk_a, sclk_b, lrclk_a, lrclk_b, sd_a, sd_b, underrun_a, underrun_b;

  int errors = 0;
  int checks = 0;

  logic [95:0] sb[$];

  // monitor state
  bit   mon_on = 1'b0;
  bit   sel = 1'b0;
  int   mon_mode = 0, mon_ch = 2, mon_f = 64;
  int   rise_cnt = 0, ur_cnt = 0, frames_done = 0, edge_viol = 0;
  int   cyc = 0, p0_cyc = 0;
  bit   have_p0 = 1'b0;
  logic sclk_prev = 1'b0, sd_prev = 1'b0, lr_prev = 1'b0;
  logic smp_sd[128];
  logic smp_lr[128];

  always #5 clk = ~clk;

  tdm_dac_transmitter #(.WIDTH(W), .SLOT_WIDTH(SW), .CHANNELS(2), .SCLK_DIV(DIV)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .frame_data(data_a), .frame_valid(valid_a), .frame_ready(ready_a),
    .sclk(sclk_a), .lrclk(lrclk_a), .sd(sd_a), .underrun(underrun_a));

  tdm_dac_transmitter #(.WIDTH(W), .SLOT_WIDTH(SW), .CHANNELS(4), .SCLK_DIV(DIV)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .frame_data(data_b), .frame_valid(valid_b), .frame_ready(ready_b),
    .sclk(sclk_b), .lrclk(lrclk_b), .sd(sd_b), .underrun(underrun_b));

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rebuild one frame from the captured samples and compare with the scoreboard.
  task automatic decode_frame();
    logic [95:0] got;
    logic [95:0] exp;
    int   lrbad, padbad, off, s, b;
    logic exp_lr;
    got = '0; lrbad = 0; padbad = 0;
    off = (mon_mode == 0) ? 1 : 0;
    for (int ch = 0; ch < mon_ch; ch++)
      for (int k = 0; k < W; k++)
        got[ch*W + (W-1-k)] = smp_sd[ch*SW + k + off];
    for (int p = 0; p < mon_f; p++) begin
      s = p / SW;
      b = p % SW;
      if (mon_mode == 2)      exp_lr = (p == mon_f - 1);
      else if (mon_mode == 1) exp_lr = (s >= mon_ch / 2);
      else                    exp_lr = ((((p + 1) % mon_f) / SW) >= mon_ch / 2);
      if (smp_lr[p] !== exp_lr) lrbad++;
      if (mon_mode == 0) begin
        if ((b == 0 || b > W) && smp_sd[p] !== 1'b0) padbad++;
      end else begin
        if (b >= W && smp_sd[p] !== 1'b0) padbad++;
      end
    end
    chk("lrclk_pattern", 96'(lrbad), 96'(0));
    chk("padding_zero", 96'(padbad), 96'(0));
    if (sb.size() == 0) begin
      chk("sb_depth", 96'(sb.size()), 96'(1));
    end else begin
      exp = sb.pop_front();
      chk("frame_data", got, exp);
      $display("frame %0d: decoded=%0h expected=%0h", frames_done, got, exp);
    end
    frames_done++;
  endtask

  // Receiver model: samples on sclk rising edges of the selected instance.
  always @(negedge clk) begin
    logic s_now, sd_now, lr_now, ur_now;
    int p;
    s_now  = sel ? sclk_b : sclk_a;
    sd_now = sel ? sd_b : sd_a;
    lr_now = sel ? lrclk_b : lrclk_a;
    ur_now = sel ? underrun_b : underrun_a;
    if (mon_on) begin
      if (ur_now) begin
        ur_cnt++;
        chk("underrun_at_load", 96'({sclk_prev, s_now}), 96'(2'b10));
      end
      if (s_now && !sclk_prev) begin
        if (sd_now !== sd_prev || lr_now !== lr_prev) edge_viol++;
        p = rise_cnt % mon_f;
        smp_sd[p] = sd_now;
        smp_lr[p] = lr_now;
        if (p == 0) begin
          if (have_p0) chk("frame_clk_len", 96'(cyc - p0_cyc), 96'(mon_f * 2 * DIV));
          p0_cyc  = cyc;
          have_p0 = 1'b1;
        end
        rise_cnt++;
        if (p == mon_f - 1) decode_frame();
      end
    end
    sclk_prev = s_now;
    sd_prev   = sd_now;
    lr_prev   = lr_now;
    cyc++;
  end

  task automatic start_mon(input int m, input int ch);
    mon_mode    = m;
    mon_ch      = ch;
    mon_f       = dac_pkg::frame_len(ch, SW);
    rise_cnt    = 0;
    ur_cnt      = 0;
    frames_done = 0;
    have_p0     = 1'b0;
    mon_on      = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b0;
    mon_on = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input logic [95:0] d);
    bit done;
    done = 1'b0;
    @(negedge clk);
    if (sel) begin data_b = d; valid_b = 1'b1; end
    else begin data_a = d[47:0]; valid_a = 1'b1; end
    for (int i = 0; i < 2000 && !done; i++) begin
      if ((sel ? ready_b : ready_a) === 1'b1) begin
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        sb.push_back(d);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chk("send_handshake", 96'(done), 96'(1));
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic wait_ready(input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      @(negedge clk);
      if ((sel ? ready_b : ready_a) === 1'b1) break;
    end
    chk("ready_within_bound", 96'(i < bound), 96'(1));
  endtask

  task automatic wait_frames(input int n, input int bound);
    for (int i = 0; i < bound && frames_done < n; i++) @(negedge clk);
    chk("frames_seen", 96'(frames_done), 96'(n));
  endtask

  task automatic two_frame_run(input logic [1:0] m);
    do_reset();
    sel = 1'b0;
    start_mon(int'(m), 2);
    mode   = m;
    enable = 1'b1;
    send({48'h0, 24'h000000, 24'hffffff});
    send({48'h0, 24'h101010, 24'h010101});
    wait_ready(600);
    enable = 1'b0;
    wait_frames(2, 1000);
    repeat (20) @(negedge clk);
    chk("sb_drained", 96'(sb.size()), 96'(0));
  endtask

  initial begin
    int n;
    reset = 1'b1; enable = 1'b0; mode = 2'd0;
    valid_a = 1'b0; valid_b = 1'b0; data_a = '0; data_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_sclk", 96'(sclk_a), 96'(0));
    chk("rst_lrclk", 96'(lrclk_a), 96'(0));
    chk("rst_sd", 96'(sd_a), 96'(0));
    chk("rst_underrun", 96'(underrun_a), 96'(0));
    chk("rst_ready", 96'(ready_a), 96'(1));
    repeat (20) @(negedge clk);
    chk("idle_sclk", 96'({sclk_a, sclk_b, sd_a, lrclk_a}), 96'(0));

    // I2S then left-justified, two frames each
    two_frame_run(2'd0);
    two_frame_run(2'd1);

    // TDM, 4 channels on the second instance
    do_reset();
    sel = 1'b1;
    start_mon(2, 4);
    mode   = 2'd2;
    enable = 1'b1;
    send({24'd4, 24'd3, 24'd2, 24'd1});
    wait_ready(600);
    enable = 1'b0;
    wait_frames(1, 1500);
    sel = 1'b0;

    // Underrun: second frame with an empty buffer
    do_reset();
    start_mon(1, 2);
    mode   = 2'd1;
    enable = 1'b1;
    send({48'h0, 24'h000000, 24'hffffff});
    sb.push_back('0);
    for (int i = 0; i < 600 && ur_cnt < 1; i++) @(negedge clk);
    enable = 1'b0;
    wait_frames(2, 800);
    repeat (300) @(negedge clk);
    chk("underrun_count", 96'(ur_cnt), 96'(1));

    // Drop enable at position 10: frame completes, then idle
    do_reset();
    start_mon(0, 2);
    mode   = 2'd0;
    enable = 1'b1;
    send({48'h0, 24'h101010, 24'h010101});
    for (int i = 0; i < 600 && rise_cnt < 10; i++) @(negedge clk);
    enable = 1'b0;
    wait_frames(1, 600);
    repeat (20) @(negedge clk);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sclk_a !== 1'b0) n++;
    end
    chk("idle_sclk_high_cycles", 96'(n), 96'(0));
    chk("rise_count", 96'(rise_cnt), 96'(64));
    chk("underrun_after_drop", 96'(ur_cnt), 96'(0));

    // Reset in the middle of a frame
    do_reset();
    start_mon(1, 2);
    mode   = 2'd1;
    enable = 1'b1;
    send({48'h0, 24'h000000, 24'hffffff});
    for (int i = 0; i < 600 && rise_cnt < 5; i++) @(negedge clk);
    for (int i = 0; i < 20 && sclk_a !== 1'b1; i++) @(negedge clk);
    chk("pre_reset_sd", 96'({sclk_a, sd_a}), 96'(2'b11));
    mon_on = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_outputs", 96'({sclk_a, lrclk_a, sd_a, underrun_a}), 96'(0));
    chk("midrst_ready", 96'(ready_a), 96'(1));
    reset = 1'b0;
    sb.delete();

    chk("sd_lr_stable_on_rise", 96'(edge_viol), 96'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdm_dac_transmitter.md
Name: tdm_dac_transmitter

Overview:
Parametrised serial audio transmitter that generalises the 2-channel I2S DAC transmitter to N channels. It supports I2S, left-justified and TDM (DSP-A) framing, a configurable slot width and an internal bit-clock divider. Sample frames arrive over a valid/ready handshake into a one-frame buffer. The block sits between the mixer/effects output and the external DAC pins.

Parameters:
WIDTH, 24, sample bits per channel; 1..SLOT_WIDTH
SLOT_WIDTH, 32, sclk periods per channel slot; bits after the sample are zero padding
CHANNELS, 2, channels per frame; must be even for I2S/LJ
SCLK_DIV, 2, clk cycles per sclk half-period; >=1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run request; sampled at frame boundaries
mode  in  2  framing mode: 0=I2S, 1=LJ, 2=TDM, 3=reserved (treated as I2S); latched on IDLE->RUN
frame_data  in  CHANNELS*WIDTH  channel k occupies bits [(k+1)*WIDTH-1 : k*WIDTH]; channel 0 is sent first
frame_valid  in  1  frame_data valid
frame_ready  out  1  buffer empty; a transfer occurs when valid && ready on a clk edge
sclk  out  1  bit clock
lrclk  out  1  word select (I2S/LJ) or frame sync (TDM)
sd  out  1  serial data, MSB first
underrun  out  1  one-cycle pulse when a frame starts with an empty buffer

Behaviour:
- Reset values: sclk=0, lrclk=0, sd=0, underrun=0, buffer empty, state=IDLE. frame_ready=1 from the first cycle after reset. Reset mid-frame aborts the frame immediately.
- All outputs are registered. sd and lrclk change only in the same clk cycle that sclk goes 1->0, so the receiver samples on sclk rising.
- Frame length is F = CHANNELS*SLOT_WIDTH sclk periods. Bit position p = 0..F-1; slot s = p / SLOT_WIDTH; bit b = p mod SLOT_WIDTH.
- Data per position: sd = channel s bit (WIDTH-1-b) for b < WIDTH, else 0.
- I2S mode: data is delayed one sclk period. Position 0 carries the last bit of the previous frame, or 0 after IDLE. Padding therefore keeps its zero bits.
- Buffer: one frame register plus a full flag. frame_ready = !full. A handshake sets full.
- Frame start (load) happens in the cycle position 0 is presented. The shift register loads from the buffer and full clears, so frame_ready rises the next cycle.
- If the buffer is empty at load while in RUN: load zeros, pulse underrun for 1 clk, and keep running.
- IDLE state: sclk=0, lrclk=0, sd=0, no divider activity.
- IDLE->RUN when enable && full. In that cycle, load occurs, position 0 is driven and sclk=0. sclk first rises SCLK_DIV cycles later.
- RUN: sclk toggles every SCLK_DIV clk cycles.
- RUN->IDLE: at the last falling edge of position F-1, if enable=0. The current frame always completes. If enable=1, position 0 of the next frame follows seamlessly.
- lrclk in I2S: 0 for slots 0..CHANNELS/2-1, 1 for the rest. It changes one sclk period before the slot MSB, i.e. it is the level for position p+1.
- lrclk in LJ: same levels, aligned to the MSB.
- lrclk in TDM: 1 only during position F-1, so the fsync pulse precedes the slot-0 MSB. The first frame after IDLE has no preceding pulse, and receivers may drop it.
- Load and handshake in the same cycle: the buffer empties and refills, and full stays 1.
- A mode change during RUN is ignored until the next IDLE->RUN.

Decomposition:
- Shared package dac_pkg: mode encodings MODE_I2S, MODE_LJ, MODE_TDM; a frame-length helper function.
- Sub-module dac_sclk_gen: divider counter, sclk register, and fall/rise strobes. It is held cleared while in IDLE.

Test Plan:
- Reset, then idle with enable=0 -> sclk/lrclk/sd/underrun all 0, frame_ready=1; assert reset mid-frame -> all outputs 0 on the next cycle.
- I2S, 2ch, WIDTH=24, SLOT=32, DIV=2; frames {L=ffffff, R=000000} then {L=010101, R=101010}. Required: frame = 256 clk, and the bench decodes L=ffffff, R=000000, then L=010101, R=101010. lrclk rises 1 sclk before the R MSB. The 8 padding bits are 0.
- LJ with the same data -> the MSB coincides with the lrclk edge; all values decode identically.
- TDM, CHANNELS=4, frame {1,2,3,4} in the low bits -> a fsync pulse 1 sclk wide at position 127, slots decode 000001..000004.
- Hold frame_valid=0 after one frame -> the second frame is all zeros, with exactly one underrun pulse in the load cycle.
- Drop enable at position 10 -> the frame finishes all 64 bits, then IDLE: sclk stays 0, and no further underrun pulses occur.
